rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
//  Reorder-buffer tag allocator and in-order commit sequencer for the architectural register file.
//  - At issue: allocates ROB tags, drives the regfile rename write (rd_control/rd/Q_value).
//  - From the CDB: captures results by tag.
//  - At commit: retires the oldest finished entry each cycle onto the regfile commit port
//    (has_commit/commit_target/Commit_Q/Commit_V).
//  - Tag 0 is reserved to mean "value ready in regfile"; it is never allocated.
// PARAMETERS
//  REG_ADDR_WIDTH  5  register address width
//  Q_WIDTH         4  ROB tag width; usable tags 1..2**Q_WIDTH-1 (ROB_SIZE = 15 entries)
// PORTS
//  clk_in         in   1               system clock
//  rst_in         in   1               asynchronous, active-high reset
//  rdy_in         in   1               global enable; 0 freezes all state
//  issue_valid    in   1               decoder presents an instruction
//  issue_has_rd   in   1               instruction writes a register
//  issue_rd       in   REG_ADDR_WIDTH  destination register
//  issue_ready    out  1               ROB not full; issue accepted iff issue_valid & issue_ready & rdy_in
//  issue_tag      out  Q_WIDTH         tag assigned to the accepted instruction
//  rd_control     out  1               regfile rename strobe
//  rd             out  REG_ADDR_WIDTH  regfile rename address
//  Q_value        out  Q_WIDTH         regfile rename tag
//  wb_valid       in   1               CDB broadcast valid
//  wb_tag         in   Q_WIDTH         CDB tag
//  wb_value       in   32              CDB result
//  flush          in   1               mispredict: discard all uncommitted entries
//  has_commit     out  1               regfile commit strobe (registered)
//  commit_target  out  REG_ADDR_WIDTH  commit register address (registered)
//  Commit_Q       out  Q_WIDTH         tag being retired (registered)
//  Commit_V       out  32              retired value (registered)
//  rob_empty      out  1               count == 0
// BEHAVIOUR
//  - Storage: entries idx 0..ROB_SIZE-1, tag = idx+1. Per entry: busy, done, has_rd, rd, value.
//  - Pointers: head and tail, each wrapping ROB_SIZE-1 -> 0. Count 0..ROB_SIZE.
//  - Reset (async): all entry flags 0, head = tail = count = 0; has_commit = 0,
//    commit_target/Commit_Q/Commit_V = 0; issue_ready = 1, rob_empty = 1.
//  - Issue is combinational, same cycle as acceptance:
//    - issue_tag = tail+1; issue_ready = (count != ROB_SIZE).
//    - rd_control = accept & issue_has_rd & (issue_rd != 0); rd = issue_rd; Q_value = issue_tag.
//    - On the clock edge: entry[tail] becomes busy (done = 0); tail and count advance.
//  - Writeback: wb_valid & wb_tag != 0 & entry[wb_tag-1].busy -> set done and store value at the edge.
//    A wb to a non-busy tag or to tag 0 is ignored.
//  - Commit (one per cycle): if count > 0 and entry[head] is busy & done at the edge:
//    - entry[head] is cleared; head advances; count decrements.
//    - Next cycle: has_commit = has_rd & rd != 0; commit_target = rd; Commit_Q = head+1; Commit_V = value.
//    - Otherwise has_commit = 0 next cycle; the other commit outputs hold their last values.
//    - Commit latency: wb at edge N -> done; retire decision at edge N+1; has_commit visible after N+1.
//  - Simultaneous events:
//    - Issue and commit in the same cycle: count unchanged, both pointers advance.
//    - Issue while full: blocked even if a commit frees a slot that cycle (no bypass).
//    - A wb to the head tag in cycle N is not committed at edge N.
//  - flush (priority over issue, wb and commit):
//    - At the edge: all busy/done cleared; head = tail = count = 0; has_commit = 0.
//    - rd_control is forced 0 while flush = 1.
//    - Clearing stale Q in the regfile is the regfile owner's job; this block only stops issuing.
//  - rdy_in = 0: no state change; has_commit forced to 0 at the edge.
//    Combinational issue outputs are gated (rd_control = 0).
//  - Tags 1..15 wrap: after tag 15 is allocated, the next allocation is tag 1.
// TESTING
//  - Reset, then issue x1..x3 on consecutive cycles -> issue_tag 1,2,3; rd_control pulses with Q_value 1,2,3.
//  - wb tag 2 before tag 1, then wb tag 1 -> commits in order Commit_Q 1 then 2,
//    each has_commit one cycle after eligibility.
//  - Issue 15 entries -> issue_ready = 0; a 16th issue_valid is ignored.
//    Commit one entry -> issue_ready = 1; the next issue gets tag 1 (wrap).
//  - Issue with rd = 0 or issue_has_rd = 0 -> rd_control = 0; at commit the entry retires with has_commit = 0.
//  - Flush with 5 busy entries and a concurrent wb -> next cycle rob_empty = 1, no has_commit,
//    next issue_tag = 1.
//  - Assert rst_in asynchronously mid-operation -> outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/rob_commit_if.sv
// Issue, writeback, flush and commit signals between the ROB commit controller and its neighbours.
interface rob_commit_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned Q_WIDTH        = 4
) ();
  logic                      issue_valid;
  logic                      issue_has_rd;
  logic [REG_ADDR_WIDTH-1:0] issue_rd;
  logic                      issue_ready;
  logic [Q_WIDTH-1:0]        issue_tag;
  logic                      rd_control;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [Q_WIDTH-1:0]        Q_value;
  logic                      wb_valid;
  logic [Q_WIDTH-1:0]        wb_tag;
  logic [31:0]               wb_value;
  logic                      flush;
  logic                      has_commit;
  logic [REG_ADDR_WIDTH-1:0] commit_target;
  logic [Q_WIDTH-1:0]        Commit_Q;
  logic [31:0]               Commit_V;
  logic                      rob_empty;

  modport master (
    output issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_value, flush,
    input  issue_ready, issue_tag, rd_control, rd, Q_value,
    input  has_commit, commit_target, Commit_Q, Commit_V, rob_empty
  );

  modport slave (
    input  issue_valid, issue_has_rd, issue_rd, wb_valid, wb_tag, wb_value, flush,
    output issue_ready, issue_tag, rd_control, rd, Q_value,
    output has_commit, commit_target, Commit_Q, Commit_V, rob_empty
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer tag allocator and in-order commit sequencer; tag = entry index + 1, tag 0 means "ready".
module rob_commit_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned Q_WIDTH        = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  rob_commit_if.slave    bus
);
  localparam int unsigned ROB_SIZE = (1 << Q_WIDTH) - 1;

  logic [ROB_SIZE-1:0]       r_busy;
  logic [ROB_SIZE-1:0]       r_done;
  logic [ROB_SIZE-1:0]       r_has_rd;
  logic [REG_ADDR_WIDTH-1:0] r_rd    [ROB_SIZE];
  logic [31:0]               r_value [ROB_SIZE];
  logic [Q_WIDTH-1:0]        r_head;
  logic [Q_WIDTH-1:0]        r_tail;
  logic [Q_WIDTH-1:0]        r_count;

  logic                      r_has_commit;
  logic [REG_ADDR_WIDTH-1:0] r_commit_target;
  logic [Q_WIDTH-1:0]        r_commit_q;
  logic [31:0]               r_commit_v;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_commit;
  logic [Q_WIDTH-1:0]        w_wb_idx;
  logic                      w_wb_hit;

  function automatic logic [Q_WIDTH-1:0] inc_ptr(input logic [Q_WIDTH-1:0] p);
    return (p == Q_WIDTH'(ROB_SIZE - 1)) ? '0 : Q_WIDTH'(p + 1'b1);
  endfunction

  // Issue handshake is combinational so the regfile rename happens in the accepting cycle
  assign w_ready  = (r_count != Q_WIDTH'(ROB_SIZE));
  assign w_accept = bus.issue_valid & w_ready & rdy_in & ~bus.flush;
  assign w_commit = (r_count != '0) & r_busy[r_head] & r_done[r_head];
  assign w_wb_idx = Q_WIDTH'(bus.wb_tag - 1'b1);
  assign w_wb_hit = bus.wb_valid & (bus.wb_tag != '0) & r_busy[w_wb_idx];

  assign bus.issue_ready   = w_ready;
  assign bus.issue_tag     = Q_WIDTH'(r_tail + 1'b1);
  assign bus.rd_control    = w_accept & bus.issue_has_rd & (bus.issue_rd != '0);
  assign bus.rd            = bus.issue_rd;
  assign bus.Q_value       = Q_WIDTH'(r_tail + 1'b1);
  assign bus.has_commit    = r_has_commit;
  assign bus.commit_target = r_commit_target;
  assign bus.Commit_Q      = r_commit_q;
  assign bus.Commit_V      = r_commit_v;
  assign bus.rob_empty     = (r_count == '0);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy          <= '0;
      r_done          <= '0;
      r_has_rd        <= '0;
      for (int i = 0; i < int'(ROB_SIZE); i++) begin
        r_rd[i]    <= '0;
        r_value[i] <= '0;
      end
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_has_commit    <= 1'b0;
      r_commit_target <= '0;
      r_commit_q      <= '0;
      r_commit_v      <= '0;
    end else if (!rdy_in) begin
      r_has_commit <= 1'b0;
    end else if (bus.flush) begin
      r_busy       <= '0;
      r_done       <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_has_commit <= 1'b0;
    end else begin
      if (w_wb_hit) begin
        r_done[w_wb_idx]  <= 1'b1;
        r_value[w_wb_idx] <= bus.wb_value;
      end
      // Retire decision uses last cycle's done flags, so a same-cycle wb to head waits one edge
      r_has_commit <= w_commit & r_has_rd[r_head] & (r_rd[r_head] != '0);
      if (w_commit) begin
        r_busy[r_head]  <= 1'b0;
        r_done[r_head]  <= 1'b0;
        r_commit_target <= r_rd[r_head];
        r_commit_q      <= Q_WIDTH'(r_head + 1'b1);
        r_commit_v      <= r_value[r_head];
        r_head          <= inc_ptr(r_head);
      end
      if (w_accept) begin
        r_busy[r_tail]   <= 1'b1;
        r_done[r_tail]   <= 1'b0;
        r_has_rd[r_tail] <= bus.issue_has_rd;
        r_rd[r_tail]     <= bus.issue_rd;
        r_tail           <= inc_ptr(r_tail);
      end
      if (w_accept && !w_commit)      r_count <= Q_WIDTH'(r_count + 1'b1);
      else if (!w_accept && w_commit) r_count <= Q_WIDTH'(r_count - 1'b1);
    end
  end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus random traffic against a queue-based ROB model.
module tb_rob_commit_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic rdy;

  rob_commit_if #(.REG_ADDR_WIDTH(5), .Q_WIDTH(4)) bus ();

  rob_commit_ctrl #(.REG_ADDR_WIDTH(5), .Q_WIDTH(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          has_rd;
    int          rd;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        q[$];
  int          nxt;
  int          checks   = 0;
  int          failures = 0;
  bit          exp_hc;
  int          exp_ct, exp_cq;
  logic [31:0] exp_cv;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    nxt    = 1;
    exp_hc = 1'b0;
    exp_ct = 0;
    exp_cq = 0;
    exp_cv = '0;
  endtask

  task automatic idle();
    bus.issue_valid  = 1'b0;
    bus.issue_has_rd = 1'b0;
    bus.issue_rd     = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_tag       = '0;
    bus.wb_value     = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic iss(input bit has_rd, input int rd);
    bus.issue_valid  = 1'b1;
    bus.issue_has_rd = has_rd;
    bus.issue_rd     = 5'(rd);
  endtask

  task automatic wb(input int tag, input logic [31:0] val);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = 4'(tag);
    bus.wb_value = val;
  endtask

  // One cycle: check combinational issue outputs, advance model at the edge, check commit outputs.
  task automatic step();
    bit   acc, cmt;
    ent_t e;
    #1;
    acc = bus.issue_valid && (q.size() < 15) && rdy && !bus.flush;
    chk("issue_ready", 32'(bus.issue_ready), 32'(q.size() < 15));
    chk("issue_tag", 32'(bus.issue_tag), 32'(nxt));
    chk("rd_control", 32'(bus.rd_control), 32'(acc && bus.issue_has_rd && bus.issue_rd != 0));
    chk("rd", 32'(bus.rd), 32'(bus.issue_rd));
    chk("q_value", 32'(bus.Q_value), 32'(nxt));
    chk("rob_empty", 32'(bus.rob_empty), 32'(q.size() == 0));
    @(posedge clk);
    if (!rdy) begin
      exp_hc = 1'b0;
    end else if (bus.flush) begin
      q.delete();
      nxt    = 1;
      exp_hc = 1'b0;
    end else begin
      cmt = (q.size() > 0) && q[0].done;
      if (cmt) begin
        e      = q.pop_front();
        exp_hc = e.has_rd && e.rd != 0;
        exp_ct = e.rd;
        exp_cq = e.tag;
        exp_cv = e.val;
      end else begin
        exp_hc = 1'b0;
      end
      if (bus.wb_valid && bus.wb_tag != 0)
        foreach (q[i]) if (q[i].tag == int'(bus.wb_tag)) begin
          q[i].done = 1'b1;
          q[i].val  = bus.wb_value;
        end
      if (acc) begin
        q.push_back('{tag: nxt, has_rd: bus.issue_has_rd, rd: int'(bus.issue_rd), done: 1'b0, val: '0});
        nxt = nxt % 15 + 1;
      end
    end
    @(negedge clk);
    chk("has_commit", 32'(bus.has_commit), 32'(exp_hc));
    chk("commit_target", 32'(bus.commit_target), 32'(exp_ct));
    chk("commit_q", 32'(bus.Commit_Q), 32'(exp_cq));
    chk("commit_v", bus.Commit_V, exp_cv);
  endtask

  initial begin
    int k;
    idle();
    rdy = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("reset_rob_empty", 32'(bus.rob_empty), 32'd1);
    chk("reset_has_commit", 32'(bus.has_commit), 32'd0);
    chk("reset_commit_q", 32'(bus.Commit_Q), 32'd0);
    chk("reset_issue_tag", 32'(bus.issue_tag), 32'd1);

    // Issue x1..x3, then out-of-order writeback
    for (int i = 1; i <= 3; i++) begin idle(); iss(1'b1, i); step(); end
    idle(); wb(2, 32'hBEEF_0002); step();
    idle(); wb(1, 32'hBEEF_0001); step();
    chk("wb_head_not_same_edge", 32'(bus.has_commit), 32'd0);
    idle(); step();
    chk("first_commit_q", 32'(bus.Commit_Q), 32'd1);
    idle(); step();
    chk("second_commit_q", 32'(bus.Commit_Q), 32'd2);
    idle(); wb(3, 32'h3333); step();
    idle(); step();

    // Fill, blocked 16th issue, free one slot, wrap to tag 1
    idle(); bus.flush = 1'b1; step();
    for (int i = 0; i < 15; i++) begin idle(); iss(1'b1, $urandom_range(1, 31)); step(); end
    chk("full_not_ready", 32'(bus.issue_ready), 32'd0);
    idle(); iss(1'b1, 9); step();
    iss(1'b1, 9); wb(1, 32'h1111); step();
    idle(); iss(1'b1, 9); step();
    chk("after_commit_ready", 32'(bus.issue_ready), 32'd1);
    chk("wrap_tag", 32'(bus.issue_tag), 32'd1);
    idle(); iss(1'b1, 9); step();

    // rd = 0 and no-rd instructions retire silently
    idle(); bus.flush = 1'b1; step();
    idle(); iss(1'b1, 0); step();
    idle(); iss(1'b0, 7); step();
    idle(); wb(1, 32'hA); step();
    idle(); wb(2, 32'hB); step();
    idle(); step();
    idle(); step();

    // Flush with 5 busy entries and a concurrent wb
    for (int i = 0; i < 5; i++) begin idle(); iss(1'b1, i + 4); step(); end
    idle(); bus.flush = 1'b1; wb(2, 32'h2222); step();
    chk("flush_empty", 32'(bus.rob_empty), 32'd1);
    chk("flush_next_tag", 32'(bus.issue_tag), 32'd1);

    // rdy_in low freezes state
    idle(); iss(1'b1, 5); step();
    idle(); wb(1, 32'h55); step();
    rdy = 1'b0;
    idle(); iss(1'b1, 6); step();
    idle(); step();
    rdy = 1'b1;
    idle(); step();

    // Async reset mid-operation after a visible commit
    idle(); iss(1'b1, 12); step();
    idle(); wb(3, 32'h77); step();
    idle(); step();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_has_commit", 32'(bus.has_commit), 32'd0);
    chk("async_commit_q", 32'(bus.Commit_Q), 32'd0);
    chk("async_commit_v", bus.Commit_V, 32'd0);
    chk("async_rob_empty", 32'(bus.rob_empty), 32'd1);
    chk("async_issue_tag", 32'(bus.issue_tag), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) != 0) iss(1'($urandom_range(0, 1)), $urandom_range(0, 31));
      if ($urandom_range(0, 9) < 6) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
          k = $urandom_range(0, q.size() - 1);
          wb(q[k].tag, $urandom);
        end else begin
          wb($urandom_range(0, 15), $urandom);
        end
      end
      bus.flush = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
